// File: rtl/button_arb_defs.sv
// rtl/button_arb_defs.sv - shared FSM encodings and overflow counter width for button_event_arbiter
package button_arb_defs;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } arb_state_t;

   localparam int OVF_W   = 8;
   localparam int OVF_MAX = (1 << OVF_W) - 1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts one past last_grant
module rr_arbiter #(
   parameter int WIDTH = 4,
   localparam int ID_BITS = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]   req,
   input  logic [ID_BITS-1:0] last_grant,
   output logic [WIDTH-1:0]   grant,
   output logic [ID_BITS-1:0] idx,
   output logic               any
);

   logic [ID_BITS-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      // last_grant itself is visited last, so it has lowest priority next round
      for (int k = 1; k <= WIDTH; k++) begin
         pos = ID_BITS'((int'(last_grant) + k) % WIDTH);
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - queues edge pulses per channel and serialises them round-robin
// BUTTON_ARB_OVERFLOW_CNT_EN adds the saturating overflow_cnt port.
module button_event_arbiter
   import button_arb_defs::*;
#(
   parameter int WIDTH    = 4,
   parameter int CNT_BITS = 2,
   localparam int ID_BITS = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   pulse_in,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [ID_BITS-1:0] evt_id,
   output logic [WIDTH-1:0]   pending
`ifdef BUTTON_ARB_OVERFLOW_CNT_EN
   ,
   output logic [OVF_W-1:0]   overflow_cnt
`endif
);

   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   arb_state_t         state, next_state;
   logic [ID_BITS-1:0] last_grant, next_last_grant, next_evt_id, win_id;
   logic [WIDTH-1:0]   offer_oh, next_offer_oh, win_grant;
   logic               win_any, accept;

`ifdef BUTTON_ARB_OVERFLOW_CNT_EN
   logic [WIDTH-1:0]   drop;
   int                 ovf_sum;
`endif

   rr_arbiter #(.WIDTH(WIDTH)) u_rr (
      .req        (pending),
      .last_grant (last_grant),
      .grant      (win_grant),
      .idx        (win_id),
      .any        (win_any)
   );

   assign evt_valid = (state == ST_OFFER);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         evt_id     <= '0;
         offer_oh   <= '0;
         last_grant <= ID_BITS'(WIDTH - 1);
      end else begin
         state      <= next_state;
         evt_id     <= next_evt_id;
         offer_oh   <= next_offer_oh;
         last_grant <= next_last_grant;
      end
   end

   // Winner is latched on entry to OFFER so late pulses cannot retarget it
   always_comb begin
      next_state      = state;
      next_evt_id     = evt_id;
      next_offer_oh   = offer_oh;
      next_last_grant = last_grant;
      accept          = 1'b0;
      if (state == ST_IDLE) begin
         if (win_any) begin
            next_state    = ST_OFFER;
            next_evt_id   = win_id;
            next_offer_oh = win_grant;
         end
      end else if (evt_ready) begin
         accept          = 1'b1;
         next_last_grant = evt_id;
         next_state      = ST_IDLE;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CNT_BITS-1:0] cnt;
      logic                inc, dec;

      assign inc = pulse_in[i];
      assign dec = accept && offer_oh[i];

      always_ff @(posedge clk) begin
         if (rst)
            cnt <= '0;
         else if (inc && !dec && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         else if (dec && !inc)
            cnt <= cnt - 1'b1;
      end

      assign pending[i] = |cnt;
`ifdef BUTTON_ARB_OVERFLOW_CNT_EN
      assign drop[i] = inc && !dec && (cnt == CNT_MAX);
`endif
   end

`ifdef BUTTON_ARB_OVERFLOW_CNT_EN
   always_comb ovf_sum = int'(overflow_cnt) + $countones(drop);

   always_ff @(posedge clk) begin
      if (rst)
         overflow_cnt <= '0;
      else if (ovf_sum > OVF_MAX)
         overflow_cnt <= '1;
      else
         overflow_cnt <= OVF_W'(ovf_sum);
   end
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] pulse_in = '0;
   logic       evt_valid;
   logic       evt_ready = 1'b0;
   logic [1:0] evt_id;
   logic [3:0] pending;
`ifdef BUTTON_ARB_OVERFLOW_CNT_EN
   logic [7:0] overflow_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   button_event_arbiter #(.WIDTH(4), .CNT_BITS(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .pulse_in     (pulse_in),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_id       (evt_id),
      .pending      (pending)
`ifdef BUTTON_ARB_OVERFLOW_CNT_EN
      ,
      .overflow_cnt (overflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      pulse_in = 4'($urandom);
      tick();
      pulse_in = 4'($urandom);
      tick();
      rst      = 1'b0;
      pulse_in = '0;
   endtask

   initial begin
      int         n;
      logic [1:0] ids [4];

      // reset with random pulses
      do_reset();
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_id", 32'(evt_id), 32'd0);
      chk("rst_pending", 32'(pending), 32'h0);
`ifdef BUTTON_ARB_OVERFLOW_CNT_EN
      chk("rst_ovf", 32'(overflow_cnt), 32'd0);
`endif

      // single event on ch2
      evt_ready = 1'b1;
      pulse_in  = 4'b0100;
      tick();
      pulse_in = '0;
      chk("single_pend_E", 32'(pending), 32'b0100);
      chk("single_valid_E", 32'(evt_valid), 32'd0);
      tick();
      chk("single_valid_E1", 32'(evt_valid), 32'd1);
      chk("single_id_E1", 32'(evt_id), 32'd2);
      tick();
      chk("single_valid_E2", 32'(evt_valid), 32'd0);
      chk("single_pend_E2", 32'(pending), 32'h0);
      tick();
      chk("single_valid_E3", 32'(evt_valid), 32'd0);

      // simultaneous 1011 -> 0, 1, 3
      do_reset();
      evt_ready = 1'b1;
      pulse_in  = 4'b1011;
      tick();
      pulse_in = '0;
      chk("sim_pend0", 32'(pending), 32'b1011);
      tick();
      chk("sim_valid_a", 32'(evt_valid), 32'd1);
      chk("sim_id_a", 32'(evt_id), 32'd0);
      tick();
      chk("sim_gap_a", 32'(evt_valid), 32'd0);
      chk("sim_pend_a", 32'(pending), 32'b1010);
      tick();
      chk("sim_valid_b", 32'(evt_valid), 32'd1);
      chk("sim_id_b", 32'(evt_id), 32'd1);
      tick();
      chk("sim_gap_b", 32'(evt_valid), 32'd0);
      chk("sim_pend_b", 32'(pending), 32'b1000);
      tick();
      chk("sim_valid_c", 32'(evt_valid), 32'd1);
      chk("sim_id_c", 32'(evt_id), 32'd3);
      tick();
      chk("sim_gap_c", 32'(evt_valid), 32'd0);
      chk("sim_pend_c", 32'(pending), 32'h0);

      // backpressure: ch1 offered, ch0 arrives mid-offer
      do_reset();
      evt_ready = 1'b0;
      pulse_in  = 4'b0010;
      tick();
      pulse_in = '0;
      tick();
      chk("bp_valid0", 32'(evt_valid), 32'd1);
      chk("bp_id0", 32'(evt_id), 32'd1);
      pulse_in = 4'b0001;
      tick();
      pulse_in = '0;
      for (int k = 0; k < 10; k++) begin
         chk("bp_hold_valid", 32'(evt_valid), 32'd1);
         chk("bp_hold_id", 32'(evt_id), 32'd1);
         tick();
      end
      chk("bp_pend", 32'(pending), 32'b0011);
      evt_ready = 1'b1;
      tick();
      chk("bp_acc1_valid", 32'(evt_valid), 32'd0);
      chk("bp_acc1_pend", 32'(pending), 32'b0001);
      tick();
      chk("bp_valid2", 32'(evt_valid), 32'd1);
      chk("bp_id2", 32'(evt_id), 32'd0);
      tick();
      chk("bp_pend_end", 32'(pending), 32'h0);

      // saturation: 5 pulses on ch3, only 3 kept
      do_reset();
      evt_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         pulse_in = 4'b1000;
         tick();
         pulse_in = '0;
         tick();
      end
      chk("sat_valid", 32'(evt_valid), 32'd1);
      chk("sat_id", 32'(evt_id), 32'd3);
      chk("sat_pend", 32'(pending), 32'b1000);
`ifdef BUTTON_ARB_OVERFLOW_CNT_EN
      chk("sat_ovf", 32'(overflow_cnt), 32'd2);
`endif
      evt_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         if (evt_valid) begin
            n++;
            chk("sat_drain_id", 32'(evt_id), 32'd3);
         end
         tick();
      end
      chk("sat_count", 32'(n), 32'd3);
      chk("sat_pend_end", 32'(pending), 32'h0);

      // reset mid-offer discards queue and restores priority
      evt_ready = 1'b0;
      pulse_in  = 4'b0110;
      tick();
      pulse_in = '0;
      tick();
      chk("midrst_pre_valid", 32'(evt_valid), 32'd1);
      do_reset();
      chk("midrst_valid", 32'(evt_valid), 32'd0);
      chk("midrst_pend", 32'(pending), 32'h0);
      chk("midrst_id", 32'(evt_id), 32'd0);
      pulse_in = 4'b0110;
      tick();
      pulse_in = '0;
      tick();
      chk("midrst_first_id", 32'(evt_id), 32'd1);

      // fairness: ch0 and ch1 kept busy
      do_reset();
      evt_ready = 1'b1;
      pulse_in  = 4'b0011;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (evt_valid && n < 4) begin
            ids[n] = evt_id;
            n++;
         end
      end
      pulse_in = '0;
      chk("fair_count", 32'(n), 32'd4);
      chk("fair_0", 32'(ids[0]), 32'd0);
      chk("fair_1", 32'(ids[1]), 32'd1);
      chk("fair_2", 32'(ids[2]), 32'd0);
      chk("fair_3", 32'(ids[3]), 32'd1);

      // pulse on ch0 in the cycle it is accepted
      do_reset();
      evt_ready = 1'b0;
      pulse_in  = 4'b0001;
      tick();
      pulse_in = '0;
      tick();
      chk("same_valid", 32'(evt_valid), 32'd1);
      evt_ready = 1'b1;
      pulse_in  = 4'b0001;
      tick();
      pulse_in = '0;
      chk("same_gap", 32'(evt_valid), 32'd0);
      chk("same_pend", 32'(pending), 32'b0001);
      tick();
      chk("same_reoffer", 32'(evt_valid), 32'd1);
      chk("same_reoffer_id", 32'(evt_id), 32'd0);
      tick();
      chk("same_pend_end", 32'(pending), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects single-cycle edge pulses from a vector of `edge_detector` outputs, one channel per button, and queues each event in a small per-channel saturating counter. It serialises the queued events onto one valid/ready event port using round-robin arbitration. It sits between the button parser chain (synchroniser → debouncer → edge_detector) and the single consumer FSM, so that simultaneous or bursty presses are neither lost nor merged.

## Interface

- `WIDTH`, 4: number of pulse channels; legal range ≥ 2.
- `CNT_BITS`, 2: width of the per-channel pending counter; max queued events per channel = 2^CNT_BITS − 1.
- `ID_BITS`, `$clog2(WIDTH)`: derived, not overridden.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `pulse_in`  in  WIDTH  one-cycle-wide rising-edge pulses from `edge_detector`.
- `evt_valid`  out  1  event offered.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_id`  out  ID_BITS  channel index of the offered event.
- `pending`  out  WIDTH  bit i = channel i counter non-zero.
- `overflow_cnt`  out  8  dropped-pulse count; present only with `BUTTON_ARB_OVERFLOW_CNT_EN`.

## Operation

- Per-channel counter `cnt[i]`:
  - +1 on `pulse_in[i]`.
  - −1 on accept (`evt_valid && evt_ready && evt_id == i`).
  - Both in the same cycle: unchanged.
- Saturation: a pulse while `cnt[i]` is at max with no simultaneous accept is dropped, and the counter holds at max.
- FSM, two states:
  - IDLE: if any `cnt` is non-zero, pick a winner by round-robin starting at `last_grant+1` (mod WIDTH). Register it into `evt_id`, set `evt_valid`, go to OFFER. Otherwise stay in IDLE.
  - OFFER: hold `evt_valid=1` and `evt_id` stable until `evt_ready`. On accept: decrement the counter, set `last_grant=evt_id`, clear `evt_valid`, return to IDLE.
- The winner is fixed once OFFER is entered; new pulses on other channels never change `evt_id` mid-offer.
- `pending` is combinational from the counters.
- Reset values: all counters 0, state IDLE, `evt_valid=0`, `evt_id=0`, `last_grant=WIDTH−1` (channel 0 has first priority), `overflow_cnt=0`.
- Reset mid-offer or with events queued: all queued events are discarded and no accept is recorded.

## Timing

- A pulse sampled at edge E makes `cnt` non-zero after E, and `evt_valid` goes high after E+1: two-cycle latency from IDLE.
- Accept at edge A: `evt_valid` is low during cycle A→A+1, and the next event is offered after A+1.
- Throughput: at most one event per 2 cycles.
- `evt_ready` is ignored while `evt_valid=0`.
- `evt_valid` never deasserts without an accept, except on `rst`.

## Configuration

- `BUTTON_ARB_OVERFLOW_CNT_EN` defined:
  - the `overflow_cnt` port exists;
  - it increments on every dropped pulse (one per channel per cycle, summed);
  - it saturates at 255.
- Not defined: the port and its logic are absent, and dropped pulses are silent. Counter behaviour is otherwise identical.

## Structure

- Shared package/header `button_arb_defs`: FSM state encodings (`ST_IDLE`, `ST_OFFER`) and the overflow counter width (8).
- One sub-module, `rr_arbiter`: purely combinational.
  - Inputs: request vector, `last_grant`.
  - Outputs: one-hot grant plus encoded index and `any` flag.
  - Instantiated once.

## Test plan

All scenarios use WIDTH=4 and CNT_BITS=2.

- Reset: hold `rst` 2 cycles during random `pulse_in` → `evt_valid=0`, `evt_id=0`, `pending=4'b0000`, `overflow_cnt=0`.
- Single event: pulse ch2 at edge E, `evt_ready=1` → `evt_valid` high after E+1 for exactly one cycle with `evt_id=2`; then `pending=0000`.
- Simultaneous: `pulse_in=4'b1011` for one cycle, `evt_ready=1` → ids delivered in order 0, 1, 3, spaced 2 cycles apart; `pending` clears bit by bit.
- Backpressure: `evt_ready=0`, pulse ch1, then pulse ch0 during OFFER → `evt_valid=1` with `evt_id=1` held for 10 cycles. Raise `evt_ready` → accept 1, then 0.
- Saturation:
  - `evt_ready=0`, pulse ch3 on 5 separate cycles → `cnt[3]=3`.
  - Release `evt_ready` → exactly 3 events with id 3.
  - With the macro defined: `overflow_cnt=2`.
- Fairness / same-cycle accept:
  - Keep ch0 and ch1 non-zero with repeated pulses → grants alternate 0, 1, 0, 1.
  - Pulse ch0 in the same cycle it is accepted → `cnt[0]` unchanged.
